// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and saturating-counter helpers for the branch predict unit.
package branch_predict_unit_pkg;

    // Branch func3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b010;
    localparam logic [2:0] F3_BGE  = 3'b011;
    localparam logic [2:0] F3_BLTU = 3'b100;
    localparam logic [2:0] F3_BGEU = 3'b101;

    // Weakly-not-taken value: 2**(ctr_w-1)-1
    function automatic int unsigned ctr_reset_val(input int unsigned ctr_w);
        return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
    endfunction

    // Increment, holding at all-ones for a ctr_w-bit counter
    function automatic int unsigned inc_sat(input int unsigned v, input int unsigned ctr_w);
        int unsigned max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

    // Decrement, holding at zero
    function automatic int unsigned dec_sat(input int unsigned v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_bht_sat_table.sv
// Direct-mapped table of saturating counters: combinational read, synchronous update.
module bht_sat_table
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned CTR_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_taken_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic               wr_taken_i
);

    localparam int unsigned Entries = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] RstVal = CTR_W'(ctr_reset_val(CTR_W));

    logic [CTR_W-1:0] ctr_q [Entries];
    logic [CTR_W-1:0] ctr_d [Entries];

    // Read returns the stored (pre-update) value; no write-to-read bypass
    assign rd_taken_o = ctr_q[rd_index_i][CTR_W-1];

    // Next-state: saturating move of the addressed counter toward the outcome
    always_comb begin
        ctr_d = ctr_q;
        if (wr_en_i) begin
            if (wr_taken_i) begin
                ctr_d[wr_index_i] = CTR_W'(inc_sat(32'(ctr_q[wr_index_i]), CTR_W));
            end else begin
                ctr_d[wr_index_i] = CTR_W'(dec_sat(32'(ctr_q[wr_index_i])));
            end
        end
    end

    // Counter storage with asynchronous reset of every entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Entries; i++) begin
                ctr_q[i] <= RstVal;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, BHT-based prediction and mispredict statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int unsigned INDEX_W   = 6,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned STAT_W    = 16,
    parameter bit          STATIC_NT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] if_index,
    output logic               pred_taken,
    input  logic               ex_branch,
    input  logic [2:0]         ex_func3,
    input  logic               ex_zero,
    input  logic               ex_neg,
    input  logic               ex_borrow,
    input  logic [INDEX_W-1:0] ex_index,
    input  logic               ex_pred_taken,
    output logic               ex_taken,
    output logic               mispredict,
    output logic               illegal_br,
    output logic [STAT_W-1:0]  stat_mispredicts
);

    logic              rd_taken;
    logic              wr_en;
    logic              cond;
    logic              undef_f3;
    logic              pred_eff;
    logic [STAT_W-1:0] stat_q, stat_d;

    bht_sat_table #(
        .INDEX_W (INDEX_W),
        .CTR_W   (CTR_W)
    ) u_bht (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_index_i (if_index),
        .rd_taken_o (rd_taken),
        .wr_en_i    (wr_en),
        .wr_index_i (ex_index),
        .wr_taken_i (ex_taken)
    );

    // Branch condition decode from ALU flags
    always_comb begin
        cond     = 1'b0;
        undef_f3 = 1'b0;
        case (ex_func3)
            F3_BEQ:  cond = ex_zero;
            F3_BNE:  cond = ~ex_zero;
            F3_BLT:  cond = ex_neg;
            F3_BGE:  cond = ex_zero | ~ex_neg;
            F3_BLTU: cond = ex_borrow;
            F3_BGEU: cond = ex_zero | ~ex_borrow;
            default: undef_f3 = 1'b1;
        endcase
    end

    // Outcome, mispredict and table write enable; static mode treats every prediction as NT
    always_comb begin
        ex_taken   = ex_branch & cond;
        illegal_br = ex_branch & undef_f3;
        pred_eff   = STATIC_NT ? 1'b0 : ex_pred_taken;
        mispredict = ex_branch & ~illegal_br & (ex_taken ^ pred_eff);
        wr_en      = ex_branch & ~illegal_br & ~STATIC_NT;
        pred_taken = STATIC_NT ? 1'b0 : rd_taken;
    end

    // Saturating mispredict statistic next-state
    always_comb begin
        stat_d = stat_q;
        if (mispredict && (stat_q != {STAT_W{1'b1}})) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    // Statistic register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_mispredicts = stat_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit with a scoreboard queue.
module tb_branch_predict_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] if_index;
    logic       ex_branch;
    logic [2:0] ex_func3;
    logic       ex_zero, ex_neg, ex_borrow;
    logic [5:0] ex_index;
    logic       ex_pred_taken;

    // Default instance
    logic        pred_taken, ex_taken, mispredict, illegal_br;
    logic [15:0] stat_mispredicts;
    // STAT_W=3 instance
    logic        pred_taken3, ex_taken3, mispredict3, illegal_br3;
    logic [2:0]  stat3;
    // STATIC_NT=1 instance
    logic        pred_taken_s, ex_taken_s, mispredict_s, illegal_br_s;
    logic [15:0] stat_s;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_index(if_index), .pred_taken(pred_taken),
        .ex_branch(ex_branch), .ex_func3(ex_func3), .ex_zero(ex_zero), .ex_neg(ex_neg),
        .ex_borrow(ex_borrow), .ex_index(ex_index), .ex_pred_taken(ex_pred_taken),
        .ex_taken(ex_taken), .mispredict(mispredict), .illegal_br(illegal_br),
        .stat_mispredicts(stat_mispredicts)
    );

    branch_predict_unit #(.STAT_W(3)) dut3 (
        .clk(clk), .rst(rst), .if_index(if_index), .pred_taken(pred_taken3),
        .ex_branch(ex_branch), .ex_func3(ex_func3), .ex_zero(ex_zero), .ex_neg(ex_neg),
        .ex_borrow(ex_borrow), .ex_index(ex_index), .ex_pred_taken(ex_pred_taken),
        .ex_taken(ex_taken3), .mispredict(mispredict3), .illegal_br(illegal_br3),
        .stat_mispredicts(stat3)
    );

    branch_predict_unit #(.STATIC_NT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .if_index(if_index), .pred_taken(pred_taken_s),
        .ex_branch(ex_branch), .ex_func3(ex_func3), .ex_zero(ex_zero), .ex_neg(ex_neg),
        .ex_borrow(ex_borrow), .ex_index(ex_index), .ex_pred_taken(ex_pred_taken),
        .ex_taken(ex_taken_s), .mispredict(mispredict_s), .illegal_br(illegal_br_s),
        .stat_mispredicts(stat_s)
    );

    typedef struct {
        int          id;
        logic [31:0] exp;
    } exp_t;

    localparam int NObs = 11;

    exp_t        sb[$];
    logic [31:0] obs_v [NObs];
    string       names [NObs] = '{"ex_taken", "illegal_br", "mispredict", "pred_taken",
                                  "stat", "stat3", "pred_taken3", "pred_taken_s",
                                  "mispredict_s", "stat_s", "illegal_br_s"};

    int bht_m [64];
    int stat_m, stat3_m, stats_m;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void calc(output logic t, output logic ill, output logic mis,
                                 output logic mis_s);
        logic c;
        case (ex_func3)
            3'd0:    c = ex_zero;
            3'd1:    c = !ex_zero;
            3'd2:    c = ex_neg;
            3'd3:    c = ex_zero || !ex_neg;
            3'd4:    c = ex_borrow;
            3'd5:    c = ex_zero || !ex_borrow;
            default: c = 1'b0;
        endcase
        t     = ex_branch && c;
        ill   = ex_branch && (ex_func3[2:1] == 2'b11);
        mis   = ex_branch && !ill && (t != ex_pred_taken);
        mis_s = ex_branch && !ill && t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        stat_m  = 0;
        stat3_m = 0;
        stats_m = 0;
    endtask

    task automatic push(input int id, input logic [31:0] e);
        exp_t x;
        x.id  = id;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Push expectations from the model, sample the DUTs, then drain the scoreboard
    task automatic check_now();
        logic t, ill, mis, mis_s, pr;
        exp_t x;
        calc(t, ill, mis, mis_s);
        pr = (bht_m[if_index] >= 2);
        push(0, 32'(t));
        push(1, 32'(ill));
        push(2, 32'(mis));
        push(3, 32'(pr));
        push(4, 32'(stat_m));
        push(5, 32'(stat3_m));
        push(6, 32'(pr));
        push(7, 32'd0);
        push(8, 32'(mis_s));
        push(9, 32'(stats_m));
        push(10, 32'(ill));
        obs_v[0]  = 32'(ex_taken);
        obs_v[1]  = 32'(illegal_br);
        obs_v[2]  = 32'(mispredict);
        obs_v[3]  = 32'(pred_taken);
        obs_v[4]  = 32'(stat_mispredicts);
        obs_v[5]  = 32'(stat3);
        obs_v[6]  = 32'(pred_taken3);
        obs_v[7]  = 32'(pred_taken_s);
        obs_v[8]  = 32'(mispredict_s);
        obs_v[9]  = 32'(stat_s);
        obs_v[10] = 32'(illegal_br_s);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            assert (obs_v[x.id] === x.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h (f3=%0d br=%0b if=%0d ex=%0d)",
                       names[x.id], obs_v[x.id], x.exp, ex_func3, ex_branch, if_index,
                       ex_index);
            end
        end
    endtask

    task automatic model_update();
        logic t, ill, mis, mis_s;
        calc(t, ill, mis, mis_s);
        if (ex_branch && !ill) begin
            if (t) bht_m[ex_index] = (bht_m[ex_index] == 3) ? 3 : bht_m[ex_index] + 1;
            else   bht_m[ex_index] = (bht_m[ex_index] == 0) ? 0 : bht_m[ex_index] - 1;
        end
        if (mis)   stat_m  = (stat_m == 65535) ? 65535 : stat_m + 1;
        if (mis)   stat3_m = (stat3_m == 7) ? 7 : stat3_m + 1;
        if (mis_s) stats_m = (stats_m == 65535) ? 65535 : stats_m + 1;
    endtask

    // One cycle: drive after negedge, check before posedge, advance model at posedge
    task automatic step(input logic br, input logic [2:0] f3, input logic z, input logic n,
                        input logic b, input logic [5:0] exi, input logic pt,
                        input logic [5:0] ifi);
        ex_branch     = br;
        ex_func3      = f3;
        ex_zero       = z;
        ex_neg        = n;
        ex_borrow     = b;
        ex_index      = exi;
        ex_pred_taken = pt;
        if_index      = ifi;
        #1;
        check_now();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_now();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] c;
        rst           = 1'b1;
        ex_branch     = 1'b0;
        ex_func3      = 3'd0;
        ex_zero       = 1'b0;
        ex_neg        = 1'b0;
        ex_borrow     = 1'b0;
        ex_index      = 6'd0;
        ex_pred_taken = 1'b0;
        if_index      = 6'd0;
        model_reset();
        #1;
        check_now();
        @(negedge clk);
        rst = 1'b0;

        // Post-reset sweep of every entry
        for (int i = 0; i < 64; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'(i));

        // Condition truth table including undefined func3
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                c = 3'(k);
                step(1'b1, 3'(f), c[2], c[1], c[0], 6'd20, 1'b0, 6'd20);
            end
        end

        // Training index 5 to saturation, then one not-taken
        pulse_reset();
        repeat (3) step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b0, 6'd5);
        step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b1, 6'd5);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd5);

        // Mispredict accounting and STAT_W=3 saturation
        pulse_reset();
        repeat (4) step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 6'd7, 1'b1, 6'd7);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd7);
        repeat (6) step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 6'd7, 1'b1, 6'd7);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd7);

        // Read/write collision on index 9
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 6'd9, 1'b0, 6'd9);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd9);

        // Async reset mid-stream with index 5 strongly taken and an update pending
        repeat (3) step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b1, 6'd3);
        ex_branch     = 1'b1;
        ex_func3      = 3'd0;
        ex_zero       = 1'b1;
        ex_index      = 6'd5;
        ex_pred_taken = 1'b1;
        if_index      = 6'd5;
        #1;
        check_now();
        rst = 1'b1;
        model_reset();
        #1;
        check_now();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd5);
        step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b0, 6'd0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
